// File: rtl/cmul_pipe_if.sv
// Valid/ready bundle for cmul_pipe: the operand side and the result side.
// The conj field exists only when CMUL_CONJ_EN is defined.
interface cmul_pipe_if #(
    parameter int DATA_W = 17,
    parameter int COEF_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a_re;
    logic signed [DATA_W-1:0] a_im;
    logic signed [COEF_W-1:0] w_re;
    logic signed [COEF_W-1:0] w_im;
`ifdef CMUL_CONJ_EN
    logic                     conj;
`endif
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] y_re;
    logic signed [DATA_W-1:0] y_im;

    modport master (
        output in_valid, a_re, a_im, w_re, w_im, out_ready,
`ifdef CMUL_CONJ_EN
        output conj,
`endif
        input  in_ready, out_valid, y_re, y_im
    );

    modport slave (
        input  in_valid, a_re, a_im, w_re, w_im, out_ready,
`ifdef CMUL_CONJ_EN
        input  conj,
`endif
        output in_ready, out_valid, y_re, y_im
    );
endinterface

// File: rtl/cmul_pipe.sv
// Three-stage elastic complex multiplier y = a*w with round-half-up and saturation.
// Defining CMUL_CONJ_EN adds a per-sample conj flag selecting y = a*conj(w).
module cmul_pipe #(
    parameter int DATA_W = 17,
    parameter int COEF_W = 8,
    parameter int FRAC_W = 7
) (
    input logic        clk,
    input logic        rst,
    cmul_pipe_if.slave bus
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [SUM_W-1:0]  HALF  = SUM_W'(1) << (FRAC_W - 1);
    localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    logic signed [DATA_W-1:0] a_re_q, a_im_q;
    logic signed [COEF_W-1:0] w_re_q, w_im_q;
    logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [SUM_W-1:0]  re_sum, im_sum;
    logic signed [DATA_W-1:0] y_re_q, y_im_q;
`ifdef CMUL_CONJ_EN
    logic conj1, conj2;
`endif

    // Sum is wide enough that adding HALF cannot overflow; the arithmetic shift floors.
    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [SUM_W-1:0] sum);
        logic signed [SUM_W-1:0] shr;
        shr = (sum + HALF) >>> FRAC_W;
        if (shr > SUM_W'(Y_MAX))
            return Y_MAX;
        else if (shr < SUM_W'(Y_MIN))
            return Y_MIN;
        else
            return shr[DATA_W-1:0];
    endfunction

    // An empty stage always accepts, so bubbles collapse toward the output.
    assign adv3 = bus.out_ready || !v3;
    assign adv2 = adv3 || !v2;
    assign adv1 = adv2 || !v1;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v3;
    assign bus.y_re      = y_re_q;
    assign bus.y_im      = y_im_q;

    always_comb begin
        re_sum = SUM_W'(p_rr) - SUM_W'(p_ii);
        im_sum = SUM_W'(p_ri) + SUM_W'(p_ir);
`ifdef CMUL_CONJ_EN
        if (conj2) begin
            re_sum = SUM_W'(p_rr) + SUM_W'(p_ii);
            im_sum = SUM_W'(p_ir) - SUM_W'(p_ri);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            a_re_q <= '0;
            a_im_q <= '0;
            w_re_q <= '0;
            w_im_q <= '0;
            p_rr   <= '0;
            p_ii   <= '0;
            p_ri   <= '0;
            p_ir   <= '0;
            y_re_q <= '0;
            y_im_q <= '0;
`ifdef CMUL_CONJ_EN
            conj1  <= 1'b0;
            conj2  <= 1'b0;
`endif
        end else begin
            if (adv1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    a_re_q <= bus.a_re;
                    a_im_q <= bus.a_im;
                    w_re_q <= bus.w_re;
                    w_im_q <= bus.w_im;
`ifdef CMUL_CONJ_EN
                    conj1  <= bus.conj;
`endif
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    p_rr  <= PROD_W'(a_re_q) * PROD_W'(w_re_q);
                    p_ii  <= PROD_W'(a_im_q) * PROD_W'(w_im_q);
                    p_ri  <= PROD_W'(a_re_q) * PROD_W'(w_im_q);
                    p_ir  <= PROD_W'(a_im_q) * PROD_W'(w_re_q);
`ifdef CMUL_CONJ_EN
                    conj2 <= conj1;
`endif
                end
            end
            // y only reloads when S3 advances, so a held result stays stable.
            if (adv3) begin
                v3 <= v2;
                if (v2) begin
                    y_re_q <= round_sat(re_sum);
                    y_im_q <= round_sat(im_sum);
                end
            end
        end
    end
endmodule

// File: doc/cmul_pipe.md
Name: cmul_pipe

Overview:
- Parametrised, pipelined successor to the combinational 17x8 twiddle multiplier used by the FFT butterfly.
- Computes a complex product y = a * w with fixed-point rescaling, round-half-up and saturation.
- Uses a valid/ready elastic pipeline so the butterfly datapath can stall without losing samples.
- Sits between the butterfly add/sub stage and the next FFT stage's buffer.

Parameters:
- DATA_W, 17, width of a_re/a_im and y_re/y_im (two's complement).
- COEF_W, 8, width of w_re/w_im (two's complement).
- FRAC_W, 7, fractional bits of the coefficient; the product is shifted right by FRAC_W. Must satisfy 1 <= FRAC_W < COEF_W.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset; asynchronous, active-high.
- in_valid, input, 1, input sample valid.
- in_ready, output, 1, block can accept a sample this cycle.
- a_re, input, DATA_W, data real part.
- a_im, input, DATA_W, data imaginary part.
- w_re, input, COEF_W, twiddle real part.
- w_im, input, COEF_W, twiddle imaginary part.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- y_re, output, DATA_W, result real part.
- y_im, output, DATA_W, result imaginary part.

Behaviour:
- Reset, asynchronous, active-high:
  - All stage valid flags clear; out_valid=0.
  - y_re=0, y_im=0; internal data registers=0.
  - in_ready=1 from the first clock edge after rst deasserts.
  - Asserting rst mid-operation discards all in-flight samples. No partial result is ever presented.
- Handshake:
  - A transfer occurs when valid&&ready on a rising edge.
  - out_valid/y_* hold stable until accepted.
  - in_ready is combinational: in_ready = !v1 || adv1.
- Pipeline, three registered stages with valid flags v1..v3:
  - S1 registers the operands.
  - S2 registers the four products: a_re*w_re, a_im*w_im, a_re*w_im, a_im*w_re. Each is DATA_W+COEF_W bits, signed.
  - S3 registers the sums, rounding and saturation; it drives y_*.
- Stage advance rules:
  - adv3 = out_ready || !v3.
  - adv2 = adv3 || !v2 (S2 moves into S3).
  - adv1 = adv2 || !v1.
  - Bubbles collapse: an empty stage always accepts.
- Latency and throughput:
  - Accept to out_valid is exactly 3 cycles with out_ready held high.
  - Full throughput is 1 sample/cycle.
  - Up to 3 samples in flight; no loss or duplication under any out_ready pattern.
- Arithmetic:
  - re_full = a_re*w_re - a_im*w_im; im_full = a_re*w_im + a_im*w_re.
  - Sums are computed at DATA_W+COEF_W+1 bits.
  - Rounding: add 2^(FRAC_W-1), then arithmetic shift right by FRAC_W (round-half-toward-+inf).
  - Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. No wrap-around is permitted.
- Boundaries:
  - Simultaneous input accept and output accept when full: allowed, throughput is kept.
  - out_ready low while full: in_ready=0, and all stages hold their contents.
  - w = -2^(COEF_W-1) with a = -2^(DATA_W-1): the result saturates to the positive maximum.

Optional Feature:
- Macro: CMUL_CONJ_EN.
- With the macro defined:
  - Adds input port conj, 1 bit, sampled with the in_valid&&in_ready transfer and carried through the pipe alongside the data.
  - conj=1 computes a * conj(w): re = a_re*w_re + a_im*w_im; im = a_im*w_re - a_re*w_im. This supports the IFFT.
  - Rounding and saturation are unchanged.
- Without the macro: no conj port, forward product only.

Test Plan:
- Reset behaviour: assert rst while 3 samples are in flight, release it -> out_valid=0 and y=0 immediately; in_ready=1; no stale output ever appears.
- Basic products, defaults, out_ready=1:
  - a=(4360,0), w=(127,0) -> y=(4326,0) exactly 3 cycles after accept.
  - a=(256,0), w=(127,0) -> y=(254,0).
- Complex product and rounding: a=(1000,-500), w=(64,64) -> y=(750,250).
- Saturation cases:
  - a=(-65536,0), w=(-128,0) -> y=(65535,0).
  - a=(65535,65535), w=(127,-127) -> y=(65535,0).
- Backpressure: stream 8 back-to-back samples while out_ready toggles 1,0,0,1,0,1,1,0... -> all 8 results appear in order, each held stable while out_ready=0; in_ready drops only when 3 samples are held.
- CMUL_CONJ_EN: a=(1000,-500), w=(64,64), conj=1 -> y=(250,-750). The same vector with conj=0 -> (750,250).
